// File: rtl/banner_pkg.sv
// Shared types and default bitmap geometry for the record banner renderer.
// Constants only; no timing or flow control involved.
package banner_pkg;

  localparam int BMP_W_DEF = 264;
  localparam int BMP_H_DEF = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/break_record_banner_render_if.sv
// Scan-position, bitmap, control pulses and banner outputs of the banner renderer.
// Plain wires; no handshake, consumers sample every cycle.
interface break_record_banner_render_if #(
  parameter int BMP_W = 264,
  parameter int BMP_H = 24
);

  logic [BMP_W*BMP_H-1:0] pixels;
  logic [9:0]             hcnt;
  logic [9:0]             vcnt;
  logic                   frame_tick;
  logic                   trigger;
  logic                   cancel;
  logic                   banner_on;
  logic                   active;
  logic                   done;

  modport master (
    output pixels, hcnt, vcnt, frame_tick, trigger, cancel,
    input  banner_on, active, done
  );

  modport slave (
    input  pixels, hcnt, vcnt, frame_tick, trigger, cancel,
    output banner_on, active, done
  );

endinterface

// File: rtl/banner_pixel_fetch.sv
// Window test and bitmap bit lookup: stage 1 registers window/col/row, lit is the stage-2 input.
// Free-running pipeline, no backpressure.
module banner_pixel_fetch
  import banner_pkg::*;
#(
  parameter int BMP_W = BMP_W_DEF,
  parameter int BMP_H = BMP_H_DEF,
  parameter int X0    = 188,
  parameter int Y0    = 228
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BMP_W*BMP_H-1:0] pixels,
  input  logic [9:0]             hcnt,
  input  logic [9:0]             vcnt,
  output logic                   lit
);

  localparam int COL_W = clog2_min1(BMP_W);
  localparam int ROW_W = clog2_min1(BMP_H);
  localparam int IDX_W = clog2_min1(BMP_W*BMP_H);

  localparam logic [10:0] H_LO = 11'(X0);
  localparam logic [10:0] H_HI = 11'(X0 + BMP_W);
  localparam logic [10:0] V_LO = 11'(Y0);
  localparam logic [10:0] V_HI = 11'(Y0 + BMP_H);

  logic [10:0]      w_h;
  logic [10:0]      w_v;
  logic             w_in_win;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [IDX_W-1:0] w_idx;

  logic             r_in_win;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  assign w_h      = {1'b0, hcnt};
  assign w_v      = {1'b0, vcnt};
  assign w_in_win = (w_h >= H_LO) && (w_h < H_HI) && (w_v >= V_LO) && (w_v < V_HI);
  assign w_col    = COL_W'(w_h - H_LO);
  assign w_row    = ROW_W'(w_v - V_LO);

  // Offsets are zeroed outside the window so the lookup index always stays in range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_win <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      r_in_win <= w_in_win;
      r_col    <= w_in_win ? w_col : '0;
      r_row    <= w_in_win ? w_row : '0;
    end
  end

  // Row MSB is the leftmost pixel, so column 0 maps to the top bit of the row.
  assign w_idx = IDX_W'(r_row) * IDX_W'(BMP_W) + IDX_W'(BMP_W - 1) - IDX_W'(r_col);
  assign lit   = r_in_win & pixels[w_idx];

endmodule

// File: rtl/break_record_banner_render.sv
// Record banner: IDLE/SHOW timer with blink, 2-cycle bitmap overlay at (X0,Y0).
// No backpressure; cancel beats trigger beats frame_tick.
module break_record_banner_render
  import banner_pkg::*;
#(
  parameter int BMP_W        = BMP_W_DEF,
  parameter int BMP_H        = BMP_H_DEF,
  parameter int X0           = 188,
  parameter int Y0           = 228,
  parameter int SHOW_FRAMES  = 180,
  parameter int BLINK_FRAMES = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  break_record_banner_render_if.slave    bus
);

  localparam int FC_W = clog2_min1(SHOW_FRAMES + 1);
  localparam int BC_W = clog2_min1(BLINK_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SHOW_FRAMES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  state_t          r_state;
  logic [FC_W-1:0] r_frame_cnt;
  logic [BC_W-1:0] r_blink_cnt;
  logic            r_phase;
  logic            r_done;
  logic            r_banner_on;

  state_t          w_state_nxt;
  logic [FC_W-1:0] w_frame_cnt_nxt;
  logic [BC_W-1:0] w_blink_cnt_nxt;
  logic            w_phase_nxt;
  logic            w_done_nxt;
  logic            w_lit;

  banner_pixel_fetch #(
    .BMP_W (BMP_W),
    .BMP_H (BMP_H),
    .X0    (X0),
    .Y0    (Y0)
  ) u_fetch (
    .clk    (clk),
    .rst_n  (rst_n),
    .pixels (bus.pixels),
    .hcnt   (bus.hcnt),
    .vcnt   (bus.vcnt),
    .lit    (w_lit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_done      <= 1'b0;
      r_banner_on <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_done      <= w_done_nxt;
      // Gating uses the current state, so the overlay dies one cycle after leaving SHOW.
      r_banner_on <= w_lit & (r_state == ST_SHOW) & r_phase;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_nxt     = r_phase;
    w_done_nxt      = 1'b0;
    if (bus.cancel) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.trigger) begin
      w_state_nxt     = ST_SHOW;
      w_frame_cnt_nxt = '0;
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b1;
    end else if (r_state == ST_SHOW && bus.frame_tick) begin
      w_frame_cnt_nxt = r_frame_cnt + 1'b1;
      if (r_frame_cnt == FC_LAST) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      if (BLINK_FRAMES == 0) begin
        w_phase_nxt = 1'b1;
      end else if (r_blink_cnt == BC_LAST) begin
        w_blink_cnt_nxt = '0;
        w_phase_nxt     = ~r_phase;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
      end
    end
  end

  assign bus.banner_on = r_banner_on;
  assign bus.active    = (r_state == ST_SHOW);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_break_record_banner_render.sv
// Directed bench for the record banner with a frame-count model checked every cycle.
module tb_break_record_banner_render;

  localparam int W     = 264;
  localparam int H     = 24;
  localparam int X0    = 188;
  localparam int Y0    = 228;
  localparam int SHOW  = 180;
  localparam int BLINK = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  break_record_banner_render_if #(.BMP_W(W), .BMP_H(H)) bus();

  break_record_banner_render #(
    .BMP_W(W), .BMP_H(H), .X0(X0), .Y0(Y0),
    .SHOW_FRAMES(SHOW), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: banner is either showing or not, with a count of frames since the last trigger.
  bit m_show = 0;
  int m_ticks = 0;
  bit p_lit = 0;
  bit e_on = 0, e_act = 0, e_done = 0;
  bit chk_en = 0;

  function automatic bit model_lit(input int h, input int v, input logic [W*H-1:0] pm);
    if (h >= X0 && h < X0 + W && v >= Y0 && v < Y0 + H)
      return pm[(v - Y0) * W + (W - 1 - (h - X0))];
    return 1'b0;
  endfunction

  function automatic bit visible(input int t);
    return (BLINK == 0) || ((t / BLINK) % 2 == 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_show = 0; m_ticks = 0; p_lit = 0;
      e_on = 0; e_act = 0; e_done = 0;
      chk_en = 1;
    end else begin
      e_on   = p_lit && m_show && visible(m_ticks);
      p_lit  = model_lit(int'(bus.hcnt), int'(bus.vcnt), bus.pixels);
      e_done = 0;
      if (bus.cancel) m_show = 0;
      else if (bus.trigger) begin
        m_show = 1; m_ticks = 0;
      end else if (m_show && bus.frame_tick) begin
        m_ticks++;
        if (m_ticks == SHOW) begin
          m_show = 0; e_done = 1;
        end
      end
      e_act = m_show;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_banner_on", bus.banner_on, e_on);
      check("model_active", bus.active, e_act);
      check("model_done", bus.done, e_done);
      if (bus.done) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1; cyc(1); bus.trigger = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1; cyc(1);
      bus.frame_tick = 1'b0; cyc(1);
    end
  endtask

  logic [W*H-1:0] pat;
  int win_tab [5][3] = '{
    '{187, 230, 0}, '{452, 230, 0}, '{300, 252, 0}, '{451, 251, 1}, '{188, 227, 0}
  };
  int dc;

  initial begin
    bus.pixels = '0; bus.hcnt = '0; bus.vcnt = '0;
    bus.frame_tick = 1'b0; bus.trigger = 1'b0; bus.cancel = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("rst_active", bus.active, 1'b0);
    check("rst_banner_on", bus.banner_on, 1'b0);
    check("rst_done", bus.done, 1'b0);

    for (int i = 0; i < W*H; i++) pat[i] = (i % 3 == 0);
    pat[263] = 1'b1; pat[262] = 1'b0; pat[527] = 1'b1;
    bus.pixels = pat;
    bus.hcnt = 10'd188; bus.vcnt = 10'd228;
    pulse_trigger();
    check("trig_active", bus.active, 1'b1);
    cyc(1);
    check("corner_bit263", bus.banner_on, 1'b1);
    bus.hcnt = 10'd189; cyc(2);
    check("bit262_dark", bus.banner_on, 1'b0);
    bus.hcnt = 10'd188; bus.vcnt = 10'd229; cyc(2);
    check("row1_bit527", bus.banner_on, 1'b1);

    bus.pixels = '1;
    for (int i = 0; i < 5; i++) begin
      bus.hcnt = 10'(win_tab[i][0]); bus.vcnt = 10'(win_tab[i][1]);
      cyc(2);
      check($sformatf("window_%0d_%0d", win_tab[i][0], win_tab[i][1]),
            bus.banner_on, win_tab[i][2] != 0);
    end

    bus.hcnt = 10'd200; bus.vcnt = 10'd230;
    pulse_trigger();
    dc = done_cnt;
    ticks(14);
    check("blink_vis_14", bus.banner_on, 1'b1);
    ticks(1);
    check("blink_off_15", bus.banner_on, 1'b0);
    ticks(14);
    check("blink_off_29", bus.banner_on, 1'b0);
    ticks(1);
    check("blink_on_30", bus.banner_on, 1'b1);
    ticks(149);
    check("active_179", bus.active, 1'b1);
    bus.frame_tick = 1'b1; cyc(1); bus.frame_tick = 1'b0;
    check("done_pulse", bus.done, 1'b1);
    check("active_fall", bus.active, 1'b0);
    cyc(1);
    check("done_single", bus.done, 1'b0);
    check("banner_drop", bus.banner_on, 1'b0);
    check("done_count_1", done_cnt == dc + 1, 1'b1);

    dc = done_cnt;
    pulse_trigger();
    ticks(100);
    pulse_trigger();
    ticks(179);
    check("retrig_active", bus.active, 1'b1);
    check("retrig_no_early_done", done_cnt == dc, 1'b1);
    ticks(1);
    check("retrig_done", done_cnt == dc + 1, 1'b1);

    bus.trigger = 1'b1; bus.cancel = 1'b1; cyc(1);
    bus.trigger = 1'b0; bus.cancel = 1'b0;
    check("cancel_trig_idle", bus.active, 1'b0);
    ticks(2);
    check("tick_in_idle", bus.active, 1'b0);

    dc = done_cnt;
    pulse_trigger();
    ticks(5);
    bus.cancel = 1'b1; cyc(1); bus.cancel = 1'b0;
    check("cancel_show", bus.active, 1'b0);
    cyc(1);
    check("cancel_banner_off", bus.banner_on, 1'b0);

    pulse_trigger();
    ticks(50);
    rst_n = 1'b0; cyc(1);
    check("rst_mid_active", bus.active, 1'b0);
    check("rst_mid_banner", bus.banner_on, 1'b0);
    rst_n = 1'b1; cyc(3);
    check("rst_mid_no_done", done_cnt == dc, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/break_record_banner_render.md
BREAK_RECORD_BANNER_RENDER -- requirements
Module: break_record_banner_render

Interface
REQ-001 SHALL have parameter BMP_W, default 264, meaning bitmap width in pixels.
REQ-002 SHALL have parameter BMP_H, default 24, meaning bitmap height in rows.
REQ-003 SHALL have parameter X0, default 188, meaning screen column of the bitmap's left edge.
REQ-004 SHALL have parameter Y0, default 228, meaning screen row of the bitmap's top edge.
REQ-005 SHALL have parameter SHOW_FRAMES, default 180, meaning banner display duration in frames.
REQ-006 SHALL have parameter BLINK_FRAMES, default 15, meaning frames per blink half-period; 0 disables blinking.
REQ-007 SHALL have one clock and a synchronous, active-low reset: clk  in  1  system/pixel clock, all state on its rising edge.
REQ-008 SHALL have rst_n  in  1  synchronous active-low reset.
REQ-009 SHALL have pixels  in  BMP_W*BMP_H  packed bitmap; row r is bits [(r+1)*BMP_W-1 : r*BMP_W], with the row's MSB as its leftmost pixel.
REQ-010 SHALL have hcnt  in  10  current scan column.
REQ-011 SHALL have vcnt  in  10  current scan row.
REQ-012 SHALL have frame_tick  in  1  one-cycle pulse once per frame.
REQ-013 SHALL have trigger  in  1  one-cycle pulse: new record achieved, start the banner.
REQ-014 SHALL have cancel  in  1  one-cycle pulse: abort the banner immediately.
REQ-015 SHALL have banner_on  out  1  registered: the pixel at (hcnt,vcnt) from two cycles earlier is lit.
REQ-016 SHALL have active  out  1  registered: FSM is in SHOW.
REQ-017 SHALL have done  out  1  registered one-cycle pulse: display period completed normally.

Function
REQ-018 SHALL implement FSM states IDLE and SHOW.
REQ-019 SHALL, in IDLE on trigger=1 with cancel=0, go to SHOW, clear frame_cnt to 0 and set blink phase to visible.
REQ-020 SHALL, in SHOW, increment frame_cnt on each frame_tick; when the increment reaches SHOW_FRAMES, go to IDLE and assert done for exactly one cycle.
REQ-021 SHALL, in SHOW on trigger=1, restart: frame_cnt=0, phase visible, no done pulse; a frame_tick in that same cycle is not counted.
REQ-022 SHALL treat cancel as higher priority than trigger and frame_tick: next state IDLE, no done pulse, from either state.
REQ-023 SHALL, when BLINK_FRAMES>0, toggle the blink phase after every BLINK_FRAMES frame_ticks counted in SHOW; when BLINK_FRAMES=0, keep the phase permanently visible.
REQ-024 SHALL, in pipeline stage 1, register in_win = (X0<=hcnt<X0+BMP_W) and (Y0<=vcnt<Y0+BMP_H), with col=hcnt-X0 and row=vcnt-Y0.
REQ-025 SHALL, in stage 2, register banner_on = in_win and active and phase_visible and pixels[row*BMP_W + (BMP_W-1-col)]; total latency is 2 cycles.
REQ-026 SHALL apply the active/phase gating from the stage-2 cycle, so banner_on drops in the cycle after state leaves SHOW.
REQ-027 SHALL size frame_cnt at clog2(SHOW_FRAMES+1) bits and the blink counter at clog2(BLINK_FRAMES+1) bits, with neither counter wrapping while in SHOW.
REQ-028 SHALL ignore frame_tick in IDLE.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, set state=IDLE, frame_cnt=0, blink counter=0, phase visible, all pipeline registers 0, and banner_on=active=done=0.
REQ-030 SHALL, on reset mid-SHOW, return to IDLE without a done pulse; banner_on is 0 from the first post-reset cycle.

Structure
REQ-031 SHALL place the state enum and the default BMP_W/BMP_H constants in shared package banner_pkg.
REQ-032 SHALL implement the 2-stage coordinate-to-bit lookup as sub-module banner_pixel_fetch (inputs pixels, hcnt, vcnt; output lit), gated in the top level.

Verification
REQ-033 SHALL cover: reset, trigger, then hcnt=188 and vcnt=228 -> banner_on equals pixels[263] two cycles later.
REQ-034 SHALL cover: in SHOW, hcnt=187 or hcnt=452 or vcnt=252 -> banner_on=0 regardless of bitmap content.
REQ-035 SHALL cover: trigger, then 180 frame_ticks -> done pulses once in the cycle after the 180th tick, and active falls at the same edge.
REQ-036 SHALL cover: trigger, then 15 frame_ticks -> banner_on forced 0 for ticks 15-29 and visible again from tick 30.
REQ-037 SHALL cover: trigger, then trigger again after 100 ticks -> done arrives only 180 ticks after the second trigger.
REQ-038 SHALL cover: cancel together with trigger in IDLE -> stays IDLE; rst_n=0 mid-SHOW -> active=0 and no done pulse.
